// File: rtl/evt_packetizer_fifo.sv
// Event packetizer: stamps granted arbiter events with a free-running timestamp and buffers
// them in a DEPTH-entry FIFO. Define EVT_TS_WRAP_MARK_EN to emit timestamp-wrap marker packets.
module evt_packetizer_fifo #(
  parameter int unsigned LVL_ADD  = 3,
  parameter int unsigned LVL0_ADD = 2,
  parameter int unsigned TS_W     = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WRAP_W   = 16,
  localparam int unsigned ROW_ADD = LVL_ADD + LVL0_ADD,
  localparam int unsigned COL_ADD = LVL_ADD + LVL0_ADD,
  localparam int unsigned WIDTH   = TS_W + ROW_ADD + COL_ADD + 1,
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                ts_en_i,
  input  logic                evt_valid_i,
  output logic                evt_ready_o,
  input  logic [LVL_ADD-1:0]  grp_row_i,
  input  logic [LVL_ADD-1:0]  grp_col_i,
  input  logic [LVL0_ADD-1:0] pix_row_i,
  input  logic [LVL0_ADD-1:0] pix_col_i,
  input  logic                polarity_i,
  output logic                pkt_valid_o,
  input  logic                pkt_ready_i,
  output logic [WIDTH-1:0]    pkt_data_o,
  output logic                pkt_marker_o,
  output logic [CNT_W-1:0]    fifo_count_o,
  output logic [TS_W-1:0]     ts_o
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef EVT_TS_WRAP_MARK_EN
  localparam int unsigned EntW = WIDTH + 1;
`else
  localparam int unsigned EntW = WIDTH;
`endif

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [EntW-1:0]  mem_q [DEPTH];
  logic [EntW-1:0]  wr_entry;
  logic [EntW-1:0]  head;
  logic [WIDTH-1:0] evt_pkt;
  logic             full, empty, evt_push, push, pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && pkt_ready_i;
  assign evt_push = evt_valid_i && evt_ready_o;
  // Group bits form the MSBs of each address.
  assign evt_pkt  = {ts_q, grp_row_i, pix_row_i, grp_col_i, pix_col_i, polarity_i};
  assign head     = mem_q[rd_ptr_q];

`ifdef EVT_TS_WRAP_MARK_EN
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              mark_pend_q, mark_pend_d;
  logic              ts_wrap, mark_push;

  assign ts_wrap      = ts_en_i && (ts_q == {TS_W{1'b1}});
  assign mark_push    = mark_pend_q && !full;
  assign evt_ready_o  = !full && !mark_push;
  assign push         = evt_push || mark_push;
  assign wr_entry     = mark_push ? {1'b1, TS_W'(wrap_cnt_q), {(ROW_ADD + COL_ADD + 1){1'b0}}}
                                  : {1'b0, evt_pkt};
  assign pkt_marker_o = !empty && head[WIDTH];

  // A wrap while a marker is still pending only bumps the count; one marker covers both.
  always_comb begin
    wrap_cnt_d  = wrap_cnt_q;
    mark_pend_d = mark_pend_q && !mark_push;
    if (ts_wrap) begin
      wrap_cnt_d  = wrap_cnt_q + WRAP_W'(1);
      mark_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrap_cnt_q  <= '0;
      mark_pend_q <= 1'b0;
    end else begin
      wrap_cnt_q  <= wrap_cnt_d;
      mark_pend_q <= mark_pend_d;
    end
  end
`else
  logic unused_wrap_w;
  assign unused_wrap_w = ^WRAP_W;
  assign evt_ready_o   = !full;
  assign push          = evt_push;
  assign wr_entry      = evt_pkt;
  assign pkt_marker_o  = 1'b0;
`endif

  assign pkt_valid_o  = !empty;
  assign pkt_data_o   = empty ? '0 : head[WIDTH-1:0];
  assign fifo_count_o = count_q;
  assign ts_o         = ts_q;

  always_comb begin
    ts_d     = ts_en_i ? ts_q + TS_W'(1) : ts_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule
